// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - registered execute stage: ALU, branch, jump and multi-cycle RV32M
package execute_pipe_pkg;
    typedef enum logic [1:0] {RS1_REG, RS1_PC, RS1_ZERO} alu_rs1_t;
    typedef enum logic [1:0] {RS2_REG, RS2_IMM, RS2_FOUR} alu_rs2_t;
    typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                              ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND} alu_op_t;
    typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} branch_op_t;
endpackage

module alu_unit import execute_pipe_pkg::*; #(
    parameter int XLEN = 32
) (
    input  alu_op_t           op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   y_o
);
    localparam int SW = $clog2(XLEN);
    logic [SW-1:0] shamt;
    assign shamt = b_i[SW-1:0];

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_SLL:  y_o = a_i << shamt;
            ALU_SLT:  y_o = XLEN'($signed(a_i) < $signed(b_i));
            ALU_SLTU: y_o = XLEN'(a_i < b_i);
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SRL:  y_o = a_i >> shamt;
            ALU_SRA:  y_o = XLEN'($signed(a_i) >>> shamt);
            ALU_OR:   y_o = a_i | b_i;
            ALU_AND:  y_o = a_i & b_i;
            default:  y_o = a_i + b_i;
        endcase
    end
endmodule

module branch_unit import execute_pipe_pkg::*; #(
    parameter int XLEN = 32
) (
    input  branch_op_t        op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic              taken_o
);
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            BR_EQ:   taken_o = (a_i == b_i);
            BR_NE:   taken_o = (a_i != b_i);
            BR_LT:   taken_o = ($signed(a_i) < $signed(b_i));
            BR_GE:   taken_o = ($signed(a_i) >= $signed(b_i));
            BR_LTU:  taken_o = (a_i < b_i);
            BR_GEU:  taken_o = (a_i >= b_i);
            default: taken_o = 1'b0;
        endcase
    end
endmodule

module execute_pipe import execute_pipe_pkg::*; #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   pc_i,
    input  alu_rs1_t          alu_rs1_i,
    input  alu_rs2_t          alu_rs2_i,
    input  alu_op_t           alu_op_code_i,
    input  branch_op_t        branch_op_i,
    input  logic              jal_en_i,
    input  logic              jalr_en_i,
    input  logic              m_en_i,
    input  logic [2:0]        m_op_i,
    input  logic [4:0]        rd_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic [4:0]        out_rd_o,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_addr_o
);
    localparam int CW       = $clog2(XLEN + MUL_CYCLES + 1);
    localparam int MUL_LAST = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              out_valid_q, redir_valid_q, q_neg_q, r_neg_q;
    logic [XLEN-1:0]   result_q, redir_addr_q, a_q, b_q, quo_q, rem_q;
    logic [4:0]        out_rd_q, rd_q;
    logic [2:0]        op_q;

    logic [XLEN-1:0]   op_a, op_b, alu_out, nm_result_d, nm_addr_d, m_result_d;
    logic              br_taken, nm_redir_d, out_free, accept;

    always_comb begin
        op_a = rs1_i;
        case (alu_rs1_i)
            RS1_PC:   op_a = pc_i;
            RS1_ZERO: op_a = '0;
            default:  op_a = rs1_i;
        endcase
        op_b = rs2_i;
        case (alu_rs2_i)
            RS2_IMM:  op_b = imm_i;
            RS2_FOUR: op_b = XLEN'(4);
            default:  op_b = rs2_i;
        endcase
    end

    alu_unit #(.XLEN(XLEN)) u_alu (.op_i(alu_op_code_i), .a_i(op_a), .b_i(op_b), .y_o(alu_out));
    branch_unit #(.XLEN(XLEN)) u_br (.op_i(branch_op_i), .a_i(rs1_i), .b_i(rs2_i), .taken_o(br_taken));

    assign out_free   = !out_valid_q || out_ready_i;
    assign in_ready_o = (state_q == S_IDLE) && !flush_i && out_free;
    assign accept     = in_valid_i && in_ready_o;

    // jal wins over jalr, which wins over a taken branch
    always_comb begin
        nm_result_d = alu_out;
        nm_addr_d   = pc_i + imm_i;
        nm_redir_d  = br_taken;
        if (jal_en_i) begin
            nm_result_d = pc_i + XLEN'(4);
            nm_redir_d  = 1'b1;
        end else if (jalr_en_i) begin
            nm_result_d = pc_i + XLEN'(4);
            nm_addr_d   = (rs1_i + imm_i) & ~XLEN'(1);
            nm_redir_d  = 1'b1;
        end
    end

    logic              div_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   abs_a, abs_b;
    assign div_signed = !m_op_i[0];
    assign a_neg      = div_signed && rs1_i[XLEN-1];
    assign b_neg      = div_signed && rs2_i[XLEN-1];
    assign abs_a      = a_neg ? -rs1_i : rs1_i;
    assign abs_b      = b_neg ? -rs2_i : rs2_i;
    assign div_zero   = (rs2_i == '0);
    assign div_ovf    = div_signed && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);

    // restoring step: borrow out of the XLEN+1-bit subtract means "does not fit"
    logic [XLEN:0]     rem_shift_d, rem_sub_d;
    logic              quo_bit_d;
    assign rem_shift_d = {rem_q, quo_q[XLEN-1]};
    assign rem_sub_d   = rem_shift_d - {1'b0, b_q};
    assign quo_bit_d   = !rem_sub_d[XLEN];

    logic              ma_s, mb_s;
    logic [2*XLEN-1:0] prod_d;
    assign ma_s   = (op_q[1:0] != 2'b11);
    assign mb_s   = (op_q[1] == 1'b0);
    assign prod_d = {{XLEN{ma_s & a_q[XLEN-1]}}, a_q} * {{XLEN{mb_s & b_q[XLEN-1]}}, b_q};

    always_comb begin
        m_result_d = '0;
        case (op_q)
            3'd0:       m_result_d = prod_d[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       m_result_d = prod_d[2*XLEN-1:XLEN];
            3'd4, 3'd5: m_result_d = q_neg_q ? -quo_q : quo_q;
            default:    m_result_d = r_neg_q ? -rem_q : rem_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;  cnt_q <= '0;
            out_valid_q <= 1'b0; redir_valid_q <= 1'b0;
            result_q <= '0; redir_addr_q <= '0; out_rd_q <= '0;
            a_q <= '0; b_q <= '0; quo_q <= '0; rem_q <= '0;
            rd_q <= '0; op_q <= '0; q_neg_q <= 1'b0; r_neg_q <= 1'b0;
        end else if (flush_i) begin
            state_q <= S_IDLE;  cnt_q <= '0;
            out_valid_q <= 1'b0; redir_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready_i) begin
                out_valid_q   <= 1'b0;
                redir_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: if (accept) begin
                    if (!m_en_i) begin
                        out_valid_q   <= 1'b1;
                        result_q      <= nm_result_d;
                        redir_valid_q <= nm_redir_d;
                        redir_addr_q  <= nm_addr_d;
                        out_rd_q      <= rd_i;
                    end else begin
                        rd_q  <= rd_i;
                        op_q  <= m_op_i;
                        cnt_q <= '0;
                        q_neg_q <= 1'b0;
                        r_neg_q <= 1'b0;
                        if (!m_op_i[2]) begin
                            a_q <= rs1_i;
                            b_q <= rs2_i;
                            state_q <= (MUL_CYCLES == 1) ? S_DONE : S_MUL;
                        end else if (div_zero) begin
                            quo_q <= '1;
                            rem_q <= rs1_i;
                            state_q <= S_DONE;
                        end else if (div_ovf) begin
                            quo_q <= rs1_i;
                            rem_q <= '0;
                            state_q <= S_DONE;
                        end else begin
                            quo_q   <= abs_a;
                            b_q     <= abs_b;
                            rem_q   <= '0;
                            q_neg_q <= a_neg ^ b_neg;
                            r_neg_q <= a_neg;
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == CW'(MUL_LAST)) begin
                        cnt_q <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DIV: begin
                    rem_q <= quo_bit_d ? rem_sub_d[XLEN-1:0] : rem_shift_d[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], quo_bit_d};
                    if (cnt_q == CW'(XLEN - 1)) begin
                        cnt_q <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: if (out_free) begin
                    out_valid_q   <= 1'b1;
                    result_q      <= m_result_d;
                    redir_valid_q <= 1'b0;
                    redir_addr_q  <= '0;
                    out_rd_q      <= rd_q;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid_o      = out_valid_q;
    assign result_o         = result_q;
    assign out_rd_o         = out_rd_q;
    assign redirect_valid_o = redir_valid_q;
    assign redirect_addr_o  = redir_addr_q;
endmodule

// File: tb/tb_execute_pipe.sv
// tb/tb_execute_pipe.sv - randomized self-checking bench for execute_pipe
module tb_execute_pipe;
    import execute_pipe_pkg::*;
    localparam int XLEN = 32;
    localparam int MUL_CYCLES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, jal_en = 1'b0, jalr_en = 1'b0, m_en = 1'b0, flush = 1'b0;
    logic [31:0] rs1 = '0, rs2 = '0, imm = '0, pc = '0;
    alu_rs1_t alu_rs1 = RS1_REG;
    alu_rs2_t alu_rs2 = RS2_REG;
    alu_op_t alu_op = ALU_ADD;
    branch_op_t br_op = BR_NONE;
    logic [2:0] m_op = '0;
    logic [4:0] rd = '0, out_rd;
    logic out_valid, out_ready = 1'b1, redirect_valid;
    logic [31:0] result, redirect_addr;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    execute_pipe #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .pc_i(pc),
        .alu_rs1_i(alu_rs1), .alu_rs2_i(alu_rs2), .alu_op_code_i(alu_op), .branch_op_i(br_op),
        .jal_en_i(jal_en), .jalr_en_i(jalr_en), .m_en_i(m_en), .m_op_i(m_op), .rd_i(rd),
        .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
        .out_rd_o(out_rd), .redirect_valid_o(redirect_valid), .redirect_addr_o(redirect_addr)
    );

    function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
        int sh = int'(b % 32);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a * (32'd1 << sh);
            3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4: return (a < b) ? 32'd1 : 32'd0;
            5: return a ^ b;
            6: return a / (32'd1 << sh);
            7: return 32'(int'(a) >>> sh);
            8: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_br(int op, logic [31:0] a, logic [31:0] b);
        case (op)
            1: return a == b;
            2: return a != b;
            3: return int'(a) < int'(b);
            4: return int'(a) >= int'(b);
            5: return a < b;
            6: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_m(int op, logic [31:0] a, logic [31:0] b);
        longint sa = longint'(int'(a));
        longint sb = longint'(int'(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        logic [63:0] p;
        case (op)
            0: begin p = sa * sb; return p[31:0]; end
            1: begin p = sa * sb; return p[63:32]; end
            2: begin p = sa * longint'(ub); return p[63:32]; end
            3: begin p = ua * ub; return p[63:32]; end
            4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
            5: begin if (b == 0) return '1; return a / b; end
            6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_lat(int op, logic [31:0] a, logic [31:0] b);
        if (op < 4) return MUL_CYCLES + 1;
        if (b == 0) return 2;
        if ((op == 4 || op == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return XLEN + 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(int op, logic [31:0] a, logic [31:0] b, logic [4:0] d);
        rs1 = a; rs2 = b; imm = '0; pc = '0; rd = d;
        alu_rs1 = RS1_REG; alu_rs2 = RS2_REG; alu_op = alu_op_t'(4'(op)); br_op = BR_NONE;
        jal_en = 1'b0; jalr_en = 1'b0; m_en = 1'b0; m_op = '0;
    endtask

    task automatic set_m(int op, logic [31:0] a, logic [31:0] b, logic [4:0] d);
        set_alu(0, a, b, d);
        m_en = 1'b1; m_op = 3'(op);
    endtask

    task automatic accept_op(input string name);
        int n = 0;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin step(); n++; end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s accept: in_ready=%b want 1", name, in_ready); end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset redirect_valid: got %b want 0", redirect_valid); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset result: got %h want 0", result); end
        n_checks++; if (redirect_addr !== 32'd0) begin n_fail++; $display("FAIL reset redirect_addr: got %h want 0", redirect_addr); end
        n_checks++; if (out_rd !== 5'd0) begin n_fail++; $display("FAIL reset out_rd: got %h want 0", out_rd); end
        rst_n = 1'b1;
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, e_res, e_addr;
        logic e_rv;
        int k, s1, s2, bo;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            set_alu(k, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 5'($urandom));
            if ($urandom_range(0, 3) == 0) rs2 = rs1;
            imm = $urandom; pc = $urandom & 32'hFFFF_FFFC;
            s1 = $urandom_range(0, 2); s2 = $urandom_range(0, 2); bo = $urandom_range(0, 6);
            alu_rs1 = alu_rs1_t'(2'(s1)); alu_rs2 = alu_rs2_t'(2'(s2)); br_op = branch_op_t'(3'(bo));
            jal_en = ($urandom_range(0, 7) == 0); jalr_en = ($urandom_range(0, 7) == 0);
            if (i == 0) begin
                set_alu(0, 32'd5, 32'd7, 5'd1);
                s1 = 0; s2 = 0; bo = 0;
            end
            a = (s1 == 0) ? rs1 : (s1 == 1) ? pc : 32'd0;
            b = (s2 == 0) ? rs2 : (s2 == 1) ? imm : 32'd4;
            e_res = ref_alu(int'(alu_op), a, b); e_addr = pc + imm; e_rv = 1'b0;
            if (jal_en) begin e_res = pc + 4; e_rv = 1'b1; end
            else if (jalr_en) begin e_res = pc + 4; e_rv = 1'b1; e_addr = (rs1 + imm) & 32'hFFFF_FFFE; end
            else if (ref_br(bo, rs1, rs2)) e_rv = 1'b1;
            in_valid = 1'b1;
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] in_ready: got %b want 1", i, in_ready); end
            step();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] out_valid: got %b want 1", i, out_valid); end
            n_checks++; if (result !== e_res) begin n_fail++; $display("FAIL b2b[%0d] result: got %h want %h", i, result, e_res); end
            n_checks++; if (out_rd !== rd) begin n_fail++; $display("FAIL b2b[%0d] out_rd: got %h want %h", i, out_rd, rd); end
            n_checks++; if (redirect_valid !== e_rv) begin n_fail++; $display("FAIL b2b[%0d] redirect_valid: got %b want %b", i, redirect_valid, e_rv); end
            if (e_rv) begin
                n_checks++; if (redirect_addr !== e_addr) begin n_fail++; $display("FAIL b2b[%0d] redirect_addr: got %h want %h", i, redirect_addr, e_addr); end
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b drain out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_jalr();
        set_alu(0, 32'h2001, 32'd0, 5'd5);
        pc = 32'h100; imm = 32'd4; jalr_en = 1'b1;
        accept_op("jalr");
        n_checks++; if (result !== 32'h104) begin n_fail++; $display("FAIL jalr result: got %h want 104", result); end
        n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL jalr redirect_valid: got %b want 1", redirect_valid); end
        n_checks++; if (redirect_addr !== 32'h2004) begin n_fail++; $display("FAIL jalr redirect_addr: got %h want 2004", redirect_addr); end
        step();
    endtask

    task automatic run_m(int op, logic [31:0] a, logic [31:0] b, input string name);
        int n = 1;
        logic ready_seen = 1'b0;
        logic [31:0] e_res = ref_m(op, a, b);
        int e_lat = ref_lat(op, a, b);
        logic [4:0] d = 5'($urandom);
        out_ready = 1'b1;
        set_m(op, a, b, d);
        accept_op(name);
        while (!out_valid && n < 100) begin
            if (in_ready) ready_seen = 1'b1;
            step();
            n++;
        end
        n_checks++; if (n != e_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, n, e_lat); end
        n_checks++; if (result !== e_res) begin n_fail++; $display("FAIL %s result: got %h want %h", name, result, e_res); end
        n_checks++; if (out_rd !== d) begin n_fail++; $display("FAIL %s out_rd: got %h want %h", name, out_rd, d); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL %s redirect_valid: got %b want 0", name, redirect_valid); end
        n_checks++; if (ready_seen !== 1'b0) begin n_fail++; $display("FAIL %s busy in_ready: got %b want 0", name, ready_seen); end
        step();
    endtask

    task automatic test_muldiv();
        logic [31:0] a, b;
        int op;
        run_m(4, 32'd100, 32'd7, "div_100_7");
        run_m(6, 32'hFFFF_FF9C, 32'd7, "rem_m100_7");
        run_m(5, 32'h1234, 32'd0, "divu_by_zero");
        run_m(6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_m(4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_m(1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
        run_m(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        for (int i = 0; i < 16; i++) begin
            op = $urandom_range(0, 7);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
            if ($urandom_range(0, 1) == 1) b = -b;
            run_m(op, a, b, $sformatf("rand_m%0d_op%0d", i, op));
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_alu(0, 32'd10, 32'd20, 5'd3);
        accept_op("bp_first");
        set_alu(1, 32'd50, 32'd8, 5'd4);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp hold%0d out_valid: got %b want 1", k, out_valid); end
            n_checks++; if (result !== 32'd30) begin n_fail++; $display("FAIL bp hold%0d result: got %h want 1e", k, result); end
            n_checks++; if (out_rd !== 5'd3) begin n_fail++; $display("FAIL bp hold%0d out_rd: got %h want 3", k, out_rd); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp hold%0d in_ready: got %b want 0", k, in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (result !== 32'd42) begin n_fail++; $display("FAIL bp second result: got %h want 2a", result); end
        n_checks++; if (out_rd !== 5'd4) begin n_fail++; $display("FAIL bp second out_rd: got %h want 4", out_rd); end
        step();
    endtask

    task automatic test_flush();
        logic seen = 1'b0;
        out_ready = 1'b1;
        set_m(4, 32'd1000, 32'd3, 5'd9);
        accept_op("flush_div");
        repeat (4) step();
        set_alu(0, 32'd1, 32'd2, 5'd10);
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush in_ready: got %b want 0", in_ready); end
        step();
        flush = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush idle in_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (result !== 32'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL flush next add: got %h/%b want 3/1", result, out_valid); end
        n_checks++; if (out_rd !== 5'd10) begin n_fail++; $display("FAIL flush next out_rd: got %h want a", out_rd); end
        step();
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush ghost result: got %b want 0", seen); end
    endtask

    task automatic test_reset_mid_div();
        logic seen = 1'b0;
        set_m(5, 32'hDEAD_BEEF, 32'd5, 5'd7);
        accept_op("rst_div");
        repeat (3) step();
        rst_n = 1'b0;
        #2;
        n_checks++; if (result !== 32'd0 || out_rd !== 5'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_div outputs: got %h/%h/%b want 0/0/0", result, out_rd, out_valid); end
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_div idle in_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_div ghost result: got %b want 0", seen); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_jalr();
        test_muldiv();
        test_backpressure();
        test_flush();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
